// File: rtl/final_logic.sv
// Receive-side VC drain: strict VC0-priority reads, routed by DEST_BIT into two output FIFOs.
// state  | meaning
// RESET  | held in reset, waits for first clock after release
// INIT   | thresholds latched, output FIFOs flushed
// IDLE   | no reads; waits for VC data and room downstream
// ACTIVE | reading VC FIFOs, one word per cycle

module final_logic_dfifo #(
    parameter int W  = 6,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic [3:0]   thr,
    output logic [W-1:0] data_out,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         error
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_data_out;
    logic          r_error;
    logic          w_full;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic [7:0]    w_cnt_ext;

    assign w_full    = (r_count == CNT_FULL);
    assign w_pop_ok  = pop & (r_count != '0);
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_push_ok = push & (~w_full | w_pop_ok);
    assign w_cnt_ext = 8'(r_count);

    always_ff @(posedge clk) begin
        if (w_push_ok && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_error    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if ((push && !w_push_ok) || (pop && !w_pop_ok)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign full         = w_full;
    assign empty        = (r_count == '0);
    // a zero threshold disables almost-full; only full then holds off reads
    assign almost_full  = (thr != 4'd0) && (w_cnt_ext >= 8'(thr));
    assign almost_empty = (r_count == (AW+1)'(1));
    assign error        = r_error;
endmodule

module final_logic #(
    parameter int data_width    = 6,
    parameter int address_width = 2,
    parameter int DEST_BIT      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            Umbral_D0,
    input  logic [3:0]            Umbral_D1,
    input  logic                  empty_fifo_VC0,
    input  logic                  empty_fifo_VC1,
    input  logic [data_width-1:0] data_out_VC0,
    input  logic [data_width-1:0] data_out_VC1,
    output logic                  pop_VC0_fifo,
    output logic                  pop_VC1_fifo,
    input  logic                  pop_D0,
    input  logic                  pop_D1,
    output logic [data_width-1:0] data_out_D0,
    output logic [data_width-1:0] data_out_D1,
    output logic                  full_fifo_D0,
    output logic                  full_fifo_D1,
    output logic                  empty_fifo_D0,
    output logic                  empty_fifo_D1,
    output logic                  almost_full_fifo_D0,
    output logic                  almost_full_fifo_D1,
    output logic                  almost_empty_fifo_D0,
    output logic                  almost_empty_fifo_D1,
    output logic                  error_D0,
    output logic                  error_D1,
    output logic                  idle_out,
    output logic                  active_out
);
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_thr_d0;
    logic [3:0]            r_thr_d1;
    logic                  r_rd_valid;
    logic                  r_rd_src;
    logic                  w_pause;
    logic                  w_flush;
    logic                  w_pop_vc0;
    logic                  w_pop_vc1;
    logic                  w_push_d0;
    logic                  w_push_d1;
    logic [data_width-1:0] w_rd_word;

    // destination is unknown until the read completes, so either FIFO filling pauses both
    assign w_pause = almost_full_fifo_D0 | full_fifo_D0 | almost_full_fifo_D1 | full_fifo_D1;
    assign w_flush = (r_state == ST_INIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop_vc0    = 1'b0;
        w_pop_vc1    = 1'b0;
        if (r_state == ST_ACTIVE) begin
            w_pop_vc0 = !empty_fifo_VC0 && !w_pause;
            w_pop_vc1 = !empty_fifo_VC1 && empty_fifo_VC0 && !w_pause;
        end
        if (init) begin
            w_next_state = ST_INIT;
        end else begin
            case (r_state)
                ST_RESET: w_next_state = ST_INIT;
                ST_INIT:  w_next_state = ST_IDLE;
                ST_IDLE: begin
                    if ((!empty_fifo_VC0 || !empty_fifo_VC1) && !w_pause) begin
                        w_next_state = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if ((empty_fifo_VC0 && empty_fifo_VC1) || w_pause) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_src   <= 1'b0;
            r_thr_d0   <= 4'd0;
            r_thr_d1   <= 4'd0;
        end else begin
            r_rd_valid <= w_pop_vc0 | w_pop_vc1;
            r_rd_src   <= w_pop_vc1;
            if (w_flush) begin
                r_thr_d0 <= Umbral_D0;
                r_thr_d1 <= Umbral_D1;
            end
        end
    end

    assign w_rd_word = r_rd_src ? data_out_VC1 : data_out_VC0;
    assign w_push_d0 = r_rd_valid & ~w_rd_word[DEST_BIT];
    assign w_push_d1 = r_rd_valid & w_rd_word[DEST_BIT];

    final_logic_dfifo #(.W(data_width), .AW(address_width)) u_d0 (
        .clk          (clk),
        .reset        (reset),
        .flush        (w_flush),
        .push         (w_push_d0),
        .push_data    (w_rd_word),
        .pop          (pop_D0),
        .thr          (r_thr_d0),
        .data_out     (data_out_D0),
        .full         (full_fifo_D0),
        .empty        (empty_fifo_D0),
        .almost_full  (almost_full_fifo_D0),
        .almost_empty (almost_empty_fifo_D0),
        .error        (error_D0)
    );

    final_logic_dfifo #(.W(data_width), .AW(address_width)) u_d1 (
        .clk          (clk),
        .reset        (reset),
        .flush        (w_flush),
        .push         (w_push_d1),
        .push_data    (w_rd_word),
        .pop          (pop_D1),
        .thr          (r_thr_d1),
        .data_out     (data_out_D1),
        .full         (full_fifo_D1),
        .empty        (empty_fifo_D1),
        .almost_full  (almost_full_fifo_D1),
        .almost_empty (almost_empty_fifo_D1),
        .error        (error_D1)
    );

    assign pop_VC0_fifo = w_pop_vc0;
    assign pop_VC1_fifo = w_pop_vc1;
    assign idle_out     = (r_state == ST_IDLE);
    assign active_out   = (r_state == ST_ACTIVE);
endmodule
